// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR generator/checker pair.
//   WORD_W    : width of one generator word
//   state_e   : checker FSM states
//   lfsr_step : generator step function F, bit-exact with the generator
package lfsr_pkg;

    localparam int WORD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    function automatic logic [WORD_W-1:0] lfsr_step(input logic [WORD_W-1:0] r);
        return {r[6] ^ r[7], r[5] ^ r[7], r[4], r[3], r[2], r[1] ^ r[7], r[1], r[0] ^ r[7]};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side checker for the LFSR generator stream.
// Self-seeds from the incoming words, confirms LOCK_CNT consecutive predictions,
// then flywheels its own prediction, counting mismatches and dropping lock after
// LOSS_CNT consecutive misses.
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-low reset
//   data_i     : received word
//   valid_i    : data_i valid this cycle
//   clear_i    : synchronous clear of err_cnt_o
//   locked_o   : checker is locked
//   err_o      : one-cycle pulse on a mismatch while locked
//   err_cnt_o  : saturating count of locked mismatches
//   expected_o : word predicted for the next valid_i
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [WORD_W-1:0] expected_o
);

    localparam int MR_W = $clog2(LOCK_CNT + 1);
    localparam int XR_W = $clog2(LOSS_CNT + 1);
    localparam logic [MR_W-1:0] LOCK_V = MR_W'(LOCK_CNT);
    localparam logic [XR_W-1:0] LOSS_V = XR_W'(LOSS_CNT);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   exp_q, exp_d;
    logic [MR_W-1:0]     match_run_q, match_run_d;
    logic [XR_W-1:0]     miss_run_q, miss_run_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                cnt_inc;

    logic [WORD_W-1:0]   step_w;
    logic                seed_ok;
    logic [MR_W-1:0]     match_run_inc;
    logic [XR_W-1:0]     miss_run_inc;

    assign step_w        = lfsr_step(data_i);
    // Fixed points of F (00, 01) would predict themselves forever; never seed from them.
    assign seed_ok       = (step_w != data_i);
    assign match_run_inc = match_run_q + MR_W'(1);
    assign miss_run_inc  = miss_run_q + XR_W'(1);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        err_d       = 1'b0;
        cnt_inc     = 1'b0;
        if (valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (seed_ok) begin
                        exp_d       = step_w;
                        match_run_d = '0;
                        state_d     = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (data_i == exp_q) begin
                        exp_d       = step_w;
                        match_run_d = match_run_inc;
                        if (match_run_inc == LOCK_V) begin
                            state_d    = ST_LOCKED;
                            miss_run_d = '0;
                        end
                    end else begin
                        match_run_d = '0;
                        if (seed_ok) exp_d = step_w;
                        else         state_d = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: prediction advances from itself, never from data_i.
                    exp_d = lfsr_step(exp_q);
                    if (data_i == exp_q) begin
                        miss_run_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        cnt_inc    = 1'b1;
                        miss_run_d = miss_run_inc;
                        if (miss_run_inc == LOSS_V) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        cnt_d = cnt_q;
        if (clear_i)                cnt_d = CNT_W'(cnt_inc);
        else if (cnt_inc && ~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            exp_q       <= '0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign locked_o   = (state_q == ST_LOCKED);
    assign err_o      = err_q;
    assign err_cnt_o  = cnt_q;
    assign expected_o = exp_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker (LOCK_CNT=4, LOSS_CNT=3, CNT_W=4).
// The driver applies one input set per cycle on the falling edge, advances a
// behavioural model and queues the expected outputs; the monitor pops and
// compares after each rising edge.
module tb_lfsr_checker;

    localparam int LOCK = 4;
    localparam int LOSS = 3;
    localparam int CW   = 4;

    typedef struct {
        logic          locked;
        logic          err;
        logic [CW-1:0] cnt;
        logic [7:0]    expw;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          valid = 1'b0;
    logic          clear = 1'b0;
    logic          locked;
    logic          err;
    logic [CW-1:0] cnt;
    logic [7:0]    expw;

    int checks = 0;
    int passed = 0;
    exp_t sb_q[$];

    // model state: 0 = idle, 1 = sync, 2 = locked
    int         m_st;
    logic [7:0] m_exp;
    int         m_match, m_miss, m_cnt;
    logic       m_err;
    logic [7:0] g;

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_n), .data_i(data), .valid_i(valid), .clear_i(clear),
        .locked_o(locked), .err_o(err), .err_cnt_o(cnt), .expected_o(expw)
    );

    // Step function written arithmetically: shift left keeping bits 1:0,
    // then fold bit 7 back in through taps 7,6,2,0.
    function automatic logic [7:0] f(input logic [7:0] r);
        logic [7:0] b;
        b = ((r << 1) & 8'hFC) | (r & 8'h03);
        return r[7] ? (b ^ 8'hC5) : b;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_st = 0; m_exp = 8'h00; m_match = 0; m_miss = 0; m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic model(input logic v, input logic [7:0] w, input logic c);
        bit inc;
        inc = 0;
        m_err = 1'b0;
        if (v) begin
            if (m_st == 0) begin
                if (f(w) != w) begin m_exp = f(w); m_match = 0; m_st = 1; end
            end else if (m_st == 1) begin
                if (w == m_exp) begin
                    m_exp = f(w); m_match++;
                    if (m_match == LOCK) begin m_st = 2; m_miss = 0; end
                end else begin
                    m_match = 0;
                    if (f(w) != w) m_exp = f(w); else m_st = 0;
                end
            end else begin
                inc = (w != m_exp);
                m_exp = f(m_exp);
                if (!inc) m_miss = 0;
                else begin
                    m_err = 1'b1; m_miss++;
                    if (m_miss == LOSS) m_st = 0;
                end
            end
        end
        if (c) m_cnt = inc ? 1 : 0;
        else if (inc && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic step(input logic v, input logic [7:0] w, input logic c);
        exp_t e;
        @(negedge clk);
        valid = v; data = w; clear = c;
        model(v, w, c);
        e.locked = (m_st == 2); e.err = m_err; e.cnt = CW'(m_cnt); e.expw = m_exp;
        sb_q.push_back(e);
    endtask

    // One generator word, optionally corrupted; the generator advances either way.
    task automatic gen(input bit corrupt, input logic c);
        logic [7:0] w;
        w = corrupt ? (g ^ 8'($urandom_range(1, 255))) : g;
        step(1'b1, w, c);
        g = f(g);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_cnt"}, int'(cnt), 0);
        chk({tag, "_exp"}, int'(expw), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("locked", int'(locked), int'(e.locked));
            chk("err",    int'(err),    int'(e.err));
            chk("cnt",    int'(cnt),    int'(e.cnt));
            chk("exp",    int'(expw),   int'(e.expw));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #3;
        reset_check("rst0");
        @(negedge clk); rst_n = 1'b1;

        // 1: lock on 02,06,0E,1E,3E
        g = 8'h02;
        repeat (5) gen(0, 0);
        @(posedge clk); #2;
        chk("t1_locked", int'(locked), 1);
        chk("t1_exp7E", int'(expw), 8'h7E);

        // 2: one wrong word then FE,3B
        gen(1, 0); gen(0, 0); gen(0, 0);
        @(posedge clk); #2;
        chk("t2_cnt1", int'(cnt), 1);
        chk("t2_locked", int'(locked), 1);

        // 3: three wrong words drop lock
        repeat (3) gen(1, 0);
        @(posedge clk); #2;
        chk("t3_cnt", int'(cnt), 4);
        chk("t3_unlocked", int'(locked), 0);

        // 4: fixed-point seeds ignored, then resync on mismatch
        step(1, 8'h00, 0); step(1, 8'h01, 0);
        step(1, 8'h02, 0); step(1, 8'h06, 0); step(1, 8'h55, 0);
        @(posedge clk); #2;
        chk("t4_reseed", int'(expw), int'(f(8'h55)));

        // 5: saturate then clear with simultaneous error
        g = 8'h02;
        repeat (5) gen(0, 0);
        repeat (17) begin gen(1, 0); gen(0, 0); end
        @(posedge clk); #2;
        chk("t5_sat", int'(cnt), 15);
        gen(1, 1);
        @(posedge clk); #2;
        chk("t5_clr1", int'(cnt), 1);

        // 6: valid gaps, then async reset while locked
        repeat (4) step(0, 8'($urandom), 0);
        gen(0, 0);
        repeat (3) step(0, 8'($urandom), 0);
        @(posedge clk); #2;
        chk("t6_gap_locked", int'(locked), 1);
        @(negedge clk); #2;
        rst_n = 1'b0; model_reset();
        #1;
        reset_check("rst_mid");
        @(negedge clk); rst_n = 1'b1;

        // randomized stream with errors, gaps, clears, reseeds and fixed points
        g = 8'($urandom_range(2, 255));
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 15)      step(0, 8'($urandom), ($urandom_range(0, 19) == 0));
            else if (r < 17) step(1, 8'($urandom_range(0, 1)), 0);
            else if (r < 18) begin g = 8'($urandom_range(2, 255)); gen(0, 0); end
            else             gen(($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
        end
        @(posedge clk); #2;
        chk("drain", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
